// File: rtl/debug_cmd_unit.sv
// Debug command sequencer between the UART RX/TX FIFOs and the MIPS core.
// It pops command words, loads instruction memory, runs or single-steps the
// core, dumps debug state, and closes every command with a status word.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | pop the next command word, latch opcode/arg, branch on opcode
// LOAD_WAIT | wait for the instruction word, pop it and schedule imem write
// RUN       | core free-runs until cpu_halt is sampled high
// STEP      | core gets a single one-cycle enable
// DUMP      | stream DUMP_WORDS debug words to TX, honouring tx_full
// ACK       | push {AC,0000,opcode}
// ERR       | push {EE,0000,opcode} for an unknown opcode
module debug_cmd_unit #(
    parameter int DBIT        = 32,
    parameter int IMEM_ADDR_W = 8,
    parameter int DUMP_WORDS  = 32,
    parameter int DUMP_ADDR_W = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_empty,
    input  logic [DBIT-1:0]        r_data,
    output logic                   rd_uart,
    input  logic                   tx_full,
    output logic                   wr_uart,
    output logic [DBIT-1:0]        w_data,
    output logic                   imem_we,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    output logic [31:0]            imem_data,
    output logic                   cpu_run,
    output logic                   cpu_step,
    input  logic                   cpu_halt,
    output logic [DUMP_ADDR_W-1:0] dbg_addr,
    input  logic [31:0]            dbg_data,
    output logic                   busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_WAIT,
        S_RUN,
        S_STEP,
        S_DUMP,
        S_ACK,
        S_ERR
    } state_t;

    localparam logic [7:0] OP_LOAD = 8'h01;
    localparam logic [7:0] OP_RUN  = 8'h02;
    localparam logic [7:0] OP_STEP = 8'h03;
    localparam logic [7:0] OP_DUMP = 8'h04;
    localparam logic [DUMP_ADDR_W-1:0] DUMP_LAST = DUMP_ADDR_W'(DUMP_WORDS - 1);

    state_t                 state_q, state_d;
    logic [7:0]             opcode_q;
    logic [IMEM_ADDR_W-1:0] arg_q;
    logic [DUMP_ADDR_W-1:0] cnt_q;
    logic                   cmd_pop;
    logic                   load_pop;
    logic                   dump_push;

    assign dbg_addr = cnt_q;
    assign busy     = (state_q != S_IDLE);

    // Next-state decode and the combinational FIFO handshakes; both strobes are
    // gated by reset so nothing is popped or pushed while reset is held.
    always_comb begin
        state_d   = state_q;
        rd_uart   = 1'b0;
        wr_uart   = 1'b0;
        w_data    = '0;
        cmd_pop   = 1'b0;
        load_pop  = 1'b0;
        dump_push = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_empty) begin
                    rd_uart = 1'b1;
                    cmd_pop = 1'b1;
                    case (r_data[31:24])
                        OP_LOAD: state_d = S_LOAD_WAIT;
                        OP_RUN:  state_d = S_RUN;
                        OP_STEP: state_d = S_STEP;
                        OP_DUMP: state_d = S_DUMP;
                        default: state_d = S_ERR;
                    endcase
                end
            end
            S_LOAD_WAIT: begin
                if (!rx_empty) begin
                    rd_uart  = 1'b1;
                    load_pop = 1'b1;
                    state_d  = S_ACK;
                end
            end
            S_RUN: begin
                if (cpu_halt) begin
                    state_d = S_ACK;
                end
            end
            S_STEP: begin
                state_d = S_ACK;
            end
            S_DUMP: begin
                if (!tx_full) begin
                    wr_uart   = 1'b1;
                    w_data    = dbg_data;
                    dump_push = 1'b1;
                    if (cnt_q == DUMP_LAST) begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (!tx_full) begin
                    wr_uart = 1'b1;
                    w_data  = {8'hAC, 16'h0000, opcode_q};
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                if (!tx_full) begin
                    wr_uart = 1'b1;
                    w_data  = {8'hEE, 16'h0000, opcode_q};
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (!reset) begin
            rd_uart   = 1'b0;
            wr_uart   = 1'b0;
            w_data    = '0;
            cmd_pop   = 1'b0;
            load_pop  = 1'b0;
            dump_push = 1'b0;
            state_d   = S_IDLE;
        end
    end

    // State register plus command latches, imem write port, core enables and
    // dump index; cpu_run/cpu_step follow the next state so they are high from
    // the first cycle in RUN/STEP and drop the cycle after leaving.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            opcode_q  <= '0;
            arg_q     <= '0;
            cnt_q     <= '0;
            imem_we   <= 1'b0;
            imem_addr <= '0;
            imem_data <= '0;
            cpu_run   <= 1'b0;
            cpu_step  <= 1'b0;
        end else begin
            state_q  <= state_d;
            imem_we  <= load_pop;
            cpu_run  <= (state_d == S_RUN);
            cpu_step <= (state_d == S_STEP);
            if (cmd_pop) begin
                opcode_q <= r_data[31:24];
                arg_q    <= r_data[IMEM_ADDR_W-1:0];
            end
            if (load_pop) begin
                imem_addr <= arg_q;
                imem_data <= r_data;
            end
            if (dump_push) begin
                cnt_q <= (cnt_q == DUMP_LAST) ? '0 : cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_debug_cmd_unit.sv
// Scoreboard bench for debug_cmd_unit: stimulus queues RX words and pushes the
// expected TX words / imem writes; negedge monitors pop and compare.
module tb_debug_cmd_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_empty;
    logic [31:0] r_data;
    logic        rd_uart;
    logic        tx_full;
    logic        wr_uart;
    logic [31:0] w_data;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        cpu_run;
    logic        cpu_step;
    logic        cpu_halt;
    logic [5:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int run_cnt = 0;
    int step_cnt = 0;
    int imem_cnt = 0;

    logic [31:0] rx_q[$];
    logic [31:0] exp_tx[$];
    logic [39:0] exp_imem[$];
    logic        pop_req = 1'b0;
    logic        bp_en = 1'b0;
    int          bp_cnt = 0;

    always #5 clk = ~clk;

    assign dbg_data = 32'h0000_1000 + {26'd0, dbg_addr};

    debug_cmd_unit dut (
        .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data),
        .rd_uart(rd_uart), .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_data(imem_data),
        .cpu_run(cpu_run), .cpu_step(cpu_step), .cpu_halt(cpu_halt),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy)
    );

    task automatic rx_update();
        rx_empty = (rx_q.size() == 0);
        r_data   = rx_empty ? 32'h0 : rx_q[0];
    endtask

    task automatic send(input logic [31:0] w);
        rx_q.push_back(w);
        rx_update();
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_done(input int maxc, input string nm);
        int k;
        logic ok;
        k  = 0;
        ok = 1'b0;
        while (k < maxc && !ok) begin
            @(posedge clk); #1;
            if (exp_tx.size() == 0 && rx_q.size() == 0 && !busy) ok = 1'b1;
            k++;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: got busy=%0d tx_left=%0d expected idle", nm, busy, exp_tx.size());
        end
    endtask

    // Monitor: counts strobes and compares every TX push and imem write.
    always @(negedge clk) begin
        if (reset) begin
            if (rd_uart) begin
                rd_cnt++;
                pop_req = 1'b1;
            end
            if (cpu_run) run_cnt++;
            if (cpu_step) step_cnt++;
            if (imem_we) begin
                imem_cnt++;
                checks++;
                if (exp_imem.size() == 0) begin
                    errors++;
                    $display("FAIL imem_unexpected: got %0h_%0h expected none", imem_addr, imem_data);
                end else begin
                    logic [39:0] e;
                    e = exp_imem.pop_front();
                    if ({imem_addr, imem_data} !== e) begin
                        errors++;
                        $display("FAIL imem_write: got %0h expected %0h", {imem_addr, imem_data}, e);
                    end
                end
            end
            if (wr_uart) begin
                checks++;
                if (tx_full) begin
                    errors++;
                    $display("FAIL tx_push_while_full: got wr_uart=1 expected 0");
                end
                checks++;
                if (exp_tx.size() == 0) begin
                    errors++;
                    $display("FAIL tx_unexpected: got %0h expected none", w_data);
                end else begin
                    logic [31:0] e;
                    e = exp_tx.pop_front();
                    if (w_data !== e) begin
                        errors++;
                        $display("FAIL tx_word: got %0h expected %0h", w_data, e);
                    end
                end
            end
        end
    end

    // RX FIFO model: pop after the edge at which the DUT consumed the word.
    always @(posedge clk) begin
        #1;
        if (pop_req) begin
            if (rx_q.size() != 0) void'(rx_q.pop_front());
            pop_req = 1'b0;
            rx_update();
        end
    end

    // TX backpressure generator: tx_full toggles every 3 cycles when enabled.
    always @(posedge clk) begin
        #1;
        if (bp_en) begin
            bp_cnt++;
            if (bp_cnt == 3) begin
                tx_full = ~tx_full;
                bp_cnt  = 0;
            end
        end else begin
            tx_full = 1'b0;
            bp_cnt  = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int r0, i0, s0, k;
        logic found;
        reset    = 1'b0;
        cpu_halt = 1'b0;
        tx_full  = 1'b0;
        rx_update();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_outs", {rd_uart, wr_uart, imem_we, cpu_run, cpu_step}, 0);
        chk("reset_dbg_addr", dbg_addr, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // LOAD
        r0 = rd_cnt; i0 = imem_cnt;
        exp_imem.push_back({8'h05, 32'h2008000A});
        exp_tx.push_back(32'hAC000001);
        send(32'h01000005);
        send(32'h2008000A);
        wait_done(50, "load");
        chk("load_rd_pulses", rd_cnt - r0, 2);
        chk("load_we_pulses", imem_cnt - i0, 1);

        // RUN, halt 20 cycles after entry
        r0 = run_cnt;
        exp_tx.push_back(32'hAC000002);
        send(32'h02000000);
        found = 1'b0; k = 0;
        while (k < 20 && !found) begin
            @(posedge clk); #1;
            if (cpu_run) found = 1'b1;
            k++;
        end
        chk("run_started", found, 1);
        repeat (20) begin @(posedge clk); #1; end
        cpu_halt = 1'b1;
        wait_done(50, "run");
        cpu_halt = 1'b0;
        chk("run_cycles", run_cnt - r0, 21);
        chk("run_dropped", cpu_run, 0);

        // RUN with halt already high
        r0 = run_cnt;
        cpu_halt = 1'b1;
        exp_tx.push_back(32'hAC000002);
        send(32'h02000000);
        wait_done(50, "run_halted");
        cpu_halt = 1'b0;
        chk("run_halted_cycles", run_cnt - r0, 1);

        // STEP then unknown opcode
        s0 = step_cnt;
        exp_tx.push_back(32'hAC000003);
        exp_tx.push_back(32'hEE00007F);
        send(32'h03000000);
        send(32'h7F000000);
        wait_done(50, "step_err");
        chk("step_cycles", step_cnt - s0, 1);

        // DUMP with backpressure
        for (int w = 0; w < 32; w++) exp_tx.push_back(32'h1000 + w);
        exp_tx.push_back(32'hAC000004);
        bp_en = 1'b1;
        send(32'h04000000);
        wait_done(400, "dump_bp");
        bp_en = 1'b0;
        chk("dump_addr_rewound", dbg_addr, 0);

        // Reset in the middle of a DUMP at i=10
        for (int w = 0; w < 10; w++) exp_tx.push_back(32'h1000 + w);
        send(32'h04000000);
        found = 1'b0; k = 0;
        while (k < 100 && !found) begin
            @(posedge clk); #1;
            if (dbg_addr == 6'd10) found = 1'b1;
            k++;
        end
        chk("dump_reached_10", found, 1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_busy", busy, 0);
        chk("midreset_outs", {rd_uart, wr_uart, imem_we, cpu_run, cpu_step}, 0);
        chk("midreset_dbg_addr", dbg_addr, 0);
        chk("midreset_w_data", w_data, 0);
        repeat (5) begin @(posedge clk); #1; end
        chk("midreset_words_left", exp_tx.size(), 0);
        for (int w = 0; w < 32; w++) exp_tx.push_back(32'h1000 + w);
        exp_tx.push_back(32'hAC000004);
        send(32'h04000000);
        wait_done(100, "dump_after_reset");

        // LOAD stalled on an empty RX FIFO
        r0 = rd_cnt; i0 = imem_cnt;
        exp_imem.push_back({8'h03, 32'hDEADBEEF});
        exp_tx.push_back(32'hAC000001);
        send(32'h01000003);
        repeat (50) begin @(posedge clk); #1; end
        chk("stall_rd_pulses", rd_cnt - r0, 1);
        chk("stall_no_we", imem_cnt - i0, 0);
        chk("stall_busy", busy, 1);
        send(32'hDEADBEEF);
        wait_done(50, "stall_load");
        chk("stall_we_pulses", imem_cnt - i0, 1);
        chk("stall_rd_total", rd_cnt - r0, 2);
        chk("imem_all_seen", exp_imem.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
